pipe_hazard_ctrl: RTL and testbench

- Central stall/flush scheduler for the 5-stage pipeline.
- Drives the stall and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the PC hold.
- Resolves load-use hazards, taken-branch/jump redirects and multi-cycle data-memory waits, with a memory-wait timeout and saturating performance counters.
- Sits beside the pipeline registers; inputs come from the ID, EX and MEM stages.

---
 rtl/pipe_hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use, redirect and data-memory waits,
// with a sticky memory-wait timeout and saturating performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             stall_idex,
  output logic             stall_exmem,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_memwb,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {StRun, StMemWait, StHalt} state_e;

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic mem_wait;
  logic load_use;

  assign mem_wait = dmem_req & ~dmem_ready;
  assign load_use = ex_memread & (ex_rd != 5'd0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  // Control outputs
  always_comb begin
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    stall_idex  = 1'b0;
    stall_exmem = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_memwb = 1'b0;
    if (state_q == StHalt || mem_wait) begin
      stall_pc    = 1'b1;
      stall_ifid  = 1'b1;
      stall_idex  = 1'b1;
      stall_exmem = 1'b1;
      flush_memwb = 1'b1;
    end else if (ex_redirect) begin
      // ID instruction is squashed, so any load-use against it is moot.
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (load_use) begin
      stall_pc   = 1'b1;
      stall_ifid = 1'b1;
      flush_idex = 1'b1;
    end
    if (rst) begin
      stall_pc    = 1'b0;
      stall_ifid  = 1'b0;
      stall_idex  = 1'b0;
      stall_exmem = 1'b0;
      flush_ifid  = 1'b0;
      flush_idex  = 1'b0;
      flush_memwb = 1'b0;
    end
  end

  // Next state and counters
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    case (state_q)
      StRun: begin
        if (mem_wait) begin
          if (MEM_TIMEOUT <= 1) begin
            state_d   = StHalt;
            timeout_d = 1'b1;
          end else begin
            state_d    = StMemWait;
            wait_cnt_d = WaitW'(1);
          end
        end
      end
      StMemWait: begin
        if (!mem_wait) begin
          state_d    = StRun;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WaitW'(MEM_TIMEOUT - 1)) begin
          state_d   = StHalt;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StRun;
    endcase

    if (stall_pc && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if ((flush_ifid || flush_idex) && flush_cnt_q != '1) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_timeout  = timeout_q;
  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a behavioural model checked every negedge plus
// directed scenarios with literal expectations.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MemTimeout = 4;
  localparam int unsigned CntW       = 3;
  localparam int          CntMax     = (1 << CntW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [4:0]      id_rs1, id_rs2, ex_rd;
  logic            id_use_rs1, id_use_rs2, ex_memread, ex_redirect, dmem_req, dmem_ready;
  logic            stall_pc, stall_ifid, stall_idex, stall_exmem;
  logic            flush_ifid, flush_idex, flush_memwb, mem_timeout;
  logic [CntW-1:0] stall_cycles, flush_events;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MemTimeout), .CNT_W(CntW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_redirect(ex_redirect),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
    .stall_exmem(stall_exmem), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .flush_memwb(flush_memwb), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: halted flag, run of consecutive wait cycles, plain integer counters.
  bit m_halt;
  int m_waits;
  int m_stall;
  int m_flush;
  bit m_timeout;

  // {stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex, flush_memwb}
  function automatic logic [6:0] exp_ctrl();
    bit hazard;
    hazard = ex_memread && ex_rd != 0 &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (rst)                             return 7'b0000000;
    if (m_halt)                          return 7'b1111001;
    if (dmem_req && !dmem_ready)         return 7'b1111001;
    if (ex_redirect)                     return 7'b0000110;
    if (hazard)                          return 7'b1100010;
    return 7'b0000000;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [6:0] o;
    if (rst) begin
      m_halt <= 0; m_waits <= 0; m_stall <= 0; m_flush <= 0; m_timeout <= 0;
    end else begin
      o = exp_ctrl();
      if (o[6]) m_stall <= (m_stall < CntMax) ? m_stall + 1 : CntMax;
      if (o[2] || o[1]) m_flush <= (m_flush < CntMax) ? m_flush + 1 : CntMax;
      if (!m_halt) begin
        if (dmem_req && !dmem_ready) begin
          m_waits <= m_waits + 1;
          if (m_waits + 1 == MemTimeout) begin
            m_halt    <= 1;
            m_timeout <= 1;
          end
        end else begin
          m_waits <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [6:0] e;
    e = exp_ctrl();
    check("model ctrl",
          int'({stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex,
                flush_memwb}), int'(e));
    check("model mem_timeout", int'(mem_timeout), int'(m_timeout));
    check("model stall_cycles", int'(stall_cycles), m_stall);
    check("model flush_events", int'(flush_events), m_flush);
  end

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; ex_rd = 0;
    ex_memread = 0; ex_redirect = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; clear_inputs();
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    ex_memread = 1; ex_rd = rd; id_rs1 = rd; id_use_rs1 = 1;
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    do_reset();
    @(negedge clk);
    check("reset stall_pc", int'(stall_pc), 0);
    check("reset stall_cycles", int'(stall_cycles), 0);

    // Load-use: one bubble, one stalled cycle
    next_cycle(); set_load_use(5);
    @(negedge clk);
    check("lu stall_pc", int'(stall_pc), 1);
    check("lu flush_idex", int'(flush_idex), 1);
    check("lu stall_idex", int'(stall_idex), 0);
    next_cycle(); clear_inputs();
    @(negedge clk);
    check("lu after stall_pc", int'(stall_pc), 0);
    check("lu stall_cycles", int'(stall_cycles), 1);

    // Redirect wins over load-use
    do_reset();
    set_load_use(7); ex_redirect = 1;
    @(negedge clk);
    check("redir flush_ifid", int'(flush_ifid), 1);
    check("redir stall_pc", int'(stall_pc), 0);
    next_cycle(); clear_inputs();
    @(negedge clk);
    check("redir flush_events", int'(flush_events), 1);
    check("redir stall_cycles", int'(stall_cycles), 0);

    // Three-cycle memory wait, with a load-use masked during the wait
    do_reset();
    for (int i = 0; i < 3; i++) begin
      dmem_req = 1; dmem_ready = 0; set_load_use(3);
      @(negedge clk);
      check("mw stall_exmem", int'(stall_exmem), 1);
      check("mw flush_idex", int'(flush_idex), 0);
      next_cycle();
    end
    clear_inputs(); dmem_req = 1; dmem_ready = 1;
    @(negedge clk);
    check("mw done stall_pc", int'(stall_pc), 0);
    next_cycle(); clear_inputs();
    @(negedge clk);
    check("mw stall_cycles", int'(stall_cycles), 3);
    check("mw mem_timeout", int'(mem_timeout), 0);

    // Timeout after exactly MemTimeout wait edges, then sticky HALT
    do_reset();
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) next_cycle();
    @(negedge clk);
    check("to before", int'(mem_timeout), 0);
    next_cycle();
    @(negedge clk);
    check("to after", int'(mem_timeout), 1);
    next_cycle(); dmem_ready = 1; ex_redirect = 1;
    @(negedge clk);
    check("halt stall_pc", int'(stall_pc), 1);
    check("halt flush_ifid", int'(flush_ifid), 0);
    for (int i = 0; i < 4; i++) next_cycle();
    @(negedge clk);
    check("halt stall_cycles sat", int'(stall_cycles), 7);
    next_cycle(); #1 rst = 1; #1;
    check("halt rst stall_pc", int'(stall_pc), 0);
    check("halt rst mem_timeout", int'(mem_timeout), 0);
    check("halt rst stall_cycles", int'(stall_cycles), 0);
    next_cycle(); rst = 0; clear_inputs();

    // Saturation of stall_cycles
    do_reset();
    set_load_use(9);
    for (int i = 0; i < 10; i++) next_cycle();
    clear_inputs();
    @(negedge clk);
    check("sat stall_cycles", int'(stall_cycles), 7);

    // x0 never hazards; rs2 path and use flags
    do_reset();
    ex_memread = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    @(negedge clk);
    check("x0 stall_pc", int'(stall_pc), 0);
    next_cycle(); clear_inputs();
    ex_memread = 1; ex_rd = 9; id_rs2 = 9; id_use_rs2 = 1; id_rs1 = 9; id_use_rs1 = 0;
    @(negedge clk);
    check("rs2 stall_pc", int'(stall_pc), 1);
    next_cycle(); id_use_rs2 = 0;
    @(negedge clk);
    check("no use stall_pc", int'(stall_pc), 0);
    next_cycle(); clear_inputs(); ex_memread = 0; ex_rd = 9; id_rs1 = 9; id_use_rs1 = 1;
    @(negedge clk);
    check("no load stall_pc", int'(stall_pc), 0);

    // Async reset between edges during MEM_WAIT
    do_reset();
    dmem_req = 1; dmem_ready = 0;
    next_cycle(); next_cycle();
    #2 rst = 1; #1;
    check("async stall_pc", int'(stall_pc), 0);
    check("async flush_memwb", int'(flush_memwb), 0);
    check("async stall_cycles", int'(stall_cycles), 0);
    next_cycle(); rst = 0; clear_inputs();
    next_cycle();
    @(negedge clk);
    check("post rst stall_pc", int'(stall_pc), 0);
    check("post rst mem_timeout", int'(mem_timeout), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
